// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types, widths and address helper for the MEM-stage SRAM unit
// Revision : 1.0
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Word index relative to the SRAM base; high bits drop off, so
  // out-of-range addresses wrap around the SRAM.
  function automatic logic [SRAM_AW-2:0] word_of(input logic [31:0] addr,
                                                 input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset[SRAM_AW:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram_if
// Purpose  : Pipeline-side request/response and SRAM pin bundle
// Revision : 1.0
// ============================================================================
interface mem_stage_sram_if;
  import mem_pkg::*;

  logic               mem_read;
  logic               mem_write;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_wdata;
  logic [SRAM_DW-1:0] sram_rdata;
  logic               sram_we_n;

  modport slave (
    input  mem_read, mem_write, addr, wdata, sram_rdata,
    output rdata, ready, sram_addr, sram_wdata, sram_we_n
  );

  modport master (
    output mem_read, mem_write, addr, wdata, sram_rdata,
    input  rdata, ready, sram_addr, sram_wdata, sram_we_n
  );

endinterface
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : sram_wait_counter
// Purpose  : Wait-state counter; tc_o marks the last cycle of a half access
// Revision : 1.0
// ============================================================================
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  assign tc_o = (count_q == 4'(WAIT_CYCLES));

  // Self-reloads at terminal count so LO hands HI a fresh count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = tc_o ? 4'd0 : count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram
// Purpose  : 32-bit load/store over a 16-bit SRAM as two waited half accesses
// Revision : 1.0
// ============================================================================
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_sram_if.slave  bus
);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0]  word_q,  word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready;
  logic                cnt_en;
  logic                cnt_tc;
  logic                req;

  assign req = bus.mem_read | bus.mem_write;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read and write resolves to the write.
          is_wr_d = bus.mem_write;
          word_d  = word_of(bus.addr, BASE_ADDR);
          wdata_d = bus.wdata;
          state_d = LO;
        end else begin
          ready = 1'b1;
        end
      end
      LO: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (!is_wr_q) rdata_d[15:0] = bus.sram_rdata;
          state_d = HI;
        end
      end
      HI: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (!is_wr_q) rdata_d[31:16] = bus.sram_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        // Always back to IDLE so the still-held request is not replayed.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready      = ready;
  assign bus.rdata      = rdata_q;
  assign bus.sram_addr  = {word_q, state_q == HI};
  assign bus.sram_wdata = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign bus.sram_we_n  = ~(is_wr_q & ((state_q == LO) | (state_q == HI)));

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_sram
// Purpose  : Self-checking bench for mem_stage_sram with a small SRAM model
// Revision : 1.0
// ============================================================================
module tb_mem_stage_sram;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [16:0] exp_word;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          low;
  } sb_t;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerrors = 0;

  sb_t  sb_q[$];
  wr_t  wq[$];

  logic [15:0] mem  [256];
  logic [15:0] mem0 [256];

  always #5 clk = ~clk;

  mem_stage_sram_if bus ();
  mem_stage_sram_if bus0 ();

  mem_stage_sram #(.WAIT_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_stage_sram #(.WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus.sram_rdata  = mem[bus.sram_addr[7:0]];
  assign bus0.sram_rdata = mem0[bus0.sram_addr[7:0]];

  always @(posedge clk) begin
    if (bus.sram_we_n == 1'b0) mem[bus.sram_addr[7:0]] <= bus.sram_wdata;
    if (bus0.sram_we_n == 1'b0) mem0[bus0.sram_addr[7:0]] <= bus0.sram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write cycle on the main DUT must match the next expected entry.
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.sram_we_n === 1'b0) begin
      if (wq.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 bus.sram_addr, bus.sram_wdata);
      end else begin
        e = wq.pop_front();
        check("write_addr", 32'(bus.sram_addr), 32'(e.a));
        check("write_data", 32'(bus.sram_wdata), 32'(e.d));
      end
    end
  end

  task automatic push_writes(input logic [16:0] w, input logic [31:0] d,
                             input int lo_n, input int hi_n);
    for (int i = 0; i < lo_n; i++) wq.push_back('{ {w, 1'b0}, d[15:0] });
    for (int i = 0; i < hi_n; i++) wq.push_back('{ {w, 1'b1}, d[31:16] });
  endtask

  task automatic access(input vec_t v, input bit hold);
    int  low;
    sb_t e;
    @(negedge clk);
    bus.mem_read  = v.rd;
    bus.mem_write = v.wr;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    sb_q.push_back('{v.exp_rdata, 9});
    if (v.wr) push_writes(v.exp_word, v.wdata, 4, 4);
    #1;
    low = 0;
    while (bus.ready !== 1'b1 && low < 50) begin
      low++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check("ready_low_cycles", 32'(low), 32'(e.low));
    check("rdata", bus.rdata, e.rdata);
    if (!hold) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask

  task automatic access0(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int low;
    @(negedge clk);
    bus0.mem_read  = rd;
    bus0.mem_write = wr;
    bus0.addr      = addr;
    bus0.wdata     = wdata;
    #1;
    low = 0;
    while (bus0.ready !== 1'b1 && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("w0_ready_low_cycles", 32'(low), 32'd3);
    check("w0_rdata", bus0.rdata, exp_rdata);
    bus0.mem_read  = 1'b0;
    bus0.mem_write = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin : stim
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0000;
      mem0[i] = 16'h0000;
    end
    mem[4]  = 16'h5678;
    mem[5]  = 16'h1234;
    mem0[4] = 16'h5678;
    mem0[5] = 16'h1234;

    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.addr = '0;  bus.wdata = '0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    //            rd    wr    addr        wdata          word   exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 17'd1, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1032,   32'h0,        17'd2, 32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 32'd1028,   32'h0,        17'd1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'd1036,   32'h0A0B0C0D, 17'd3, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1036,   32'h0,        17'd3, 32'h0A0B0C0D};
    vecs[5] = '{1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 17'd0, 32'h0A0B0C0D};
    vecs[6] = '{1'b1, 1'b0, 32'd1024,   32'h0,        17'd0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'd1031,   32'h11223344, 17'd1, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 1'b0, 32'd1030,   32'h0,        17'd1, 32'h11223344};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus.ready), 32'd1);
      check("idle_we_n", 32'(bus.sram_we_n), 32'd1);
      check("idle_rdata", bus.rdata, 32'd0);
      check("idle_sram_addr", 32'(bus.sram_addr), 32'd0);
    end

    for (int i = 0; i < 9; i++) access(vecs[i], 1'b0);

    // Load held through DONE, then a store issued on the following IDLE cycle.
    access('{1'b1, 1'b0, 32'd1032, 32'h0, 17'd2, 32'h12345678}, 1'b1);
    access('{1'b0, 1'b1, 32'd1040, 32'h55AA66BB, 17'd4, 32'h12345678}, 1'b0);
    access('{1'b1, 1'b0, 32'd1040, 32'h0, 17'd4, 32'h55AA66BB}, 1'b0);

    // Reset during the high half of a write.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.addr      = 32'd1044;
    bus.wdata     = 32'h77778888;
    push_writes(17'd5, 32'h77778888, 4, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sram_addr !== 18'd11 && n < 50);
    check("reach_hi_half", 32'(n < 50), 32'd1);
    #2;
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    #1;
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_ready", 32'(bus.ready), 32'd1);
    check("pending_writes", 32'(wq.size()), 32'd0);
    check("partial_write_lo", 32'(mem[10]), 32'h8888);

    access0(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678);
    access0(1'b1, 1'b1, 32'd1032, 32'hFFFF0001, 32'h12345678);
    access0(1'b1, 1'b0, 32'd1032, 32'h0, 32'hFFFF0001);

    repeat (2) @(negedge clk);
    check("final_pending_writes", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
